// File: rtl/noc_rr_input_arbiter.sv
// N-input round-robin arbiter driving an output-port FIFO write side.
// Define ARB_PKT_LOCK_EN to hold the grant from head to tail flit; otherwise arbitration is per flit.
module noc_rr_input_arbiter #(
  parameter int N_IN     = 4,
  parameter int DW       = 64,
  parameter int TAIL_BIT = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IN-1:0]    in_valid,
  input  logic [N_IN*DW-1:0] in_data,
  output logic [N_IN-1:0]    in_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_din,
  output logic [N_IN-1:0]    grant,
  output logic               locked
);
  localparam int PW = $clog2(N_IN);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [PW-1:0] r_owner, w_owner_nxt;

  logic          w_found;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_g;
  logic          w_gnt_vld;
  logic [PW-1:0] w_ptr_inc;
  logic          w_tail;

  // Rotating priority search starting at r_ptr; explicit wrap keeps non-power-of-2 N_IN correct.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!w_found && in_valid[idx]) begin
        w_found = 1'b1;
        w_sel   = PW'(idx);
      end
    end
  end

  // Outputs are gated by reset so nothing is granted while rst is held low.
  assign w_g       = (r_state == S_LOCKED) ? r_owner : w_sel;
  assign w_gnt_vld = rst & ((r_state == S_LOCKED) | w_found);
  assign grant     = w_gnt_vld ? (N_IN'(1) << w_g) : '0;
  assign in_ready  = grant & {N_IN{~fifo_full}};
  assign fifo_wr_en = w_gnt_vld & in_valid[w_g] & ~fifo_full;
  assign fifo_din   = w_gnt_vld ? in_data[int'(w_g)*DW +: DW] : '0;
  assign w_ptr_inc  = (w_g == PW'(N_IN-1)) ? '0 : w_g + PW'(1);

`ifdef ARB_PKT_LOCK_EN
  assign w_tail = fifo_din[TAIL_BIT];
  assign locked = rst & (r_state == S_LOCKED);
`else
  logic w_unused_tail;
  assign w_unused_tail = fifo_din[TAIL_BIT];
  assign w_tail = 1'b1;
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // State only moves on an actual write; full or bubble cycles leave everything untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    if (fifo_wr_en) begin
      case (r_state)
        S_IDLE: begin
          if (w_tail) begin
            w_ptr_nxt = w_ptr_inc;
          end else begin
            w_state_nxt = S_LOCKED;
            w_owner_nxt = w_g;
          end
        end
        S_LOCKED: begin
          if (w_tail) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_ptr_inc;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule
